// File: rtl/peridot_infoblock_pkg.sv
// Shared constants, state encoding and byte helpers for the PERIDOT board info-block image.
// The image starts with a 10-byte header and is followed by the UID in ASCII hex.
package peridot_infoblock_pkg;

   localparam int unsigned HDR_LEN  = 10;
   localparam int unsigned UID_BASE = 10;

   localparam logic [7:0] HDR_J = 8'h4a;
   localparam logic [7:0] HDR_7 = 8'h37;
   localparam logic [7:0] HDR_W = 8'h57;
   localparam logic [7:0] HDR_2 = 8'h32;
   localparam logic [7:0] HDR_9 = 8'h39;
   localparam logic [7:0] HDR_3 = 8'h33;

   typedef logic [2:0] state_t;

   localparam state_t S_WAIT  = 3'd0;
   localparam state_t S_REQ   = 3'd1;
   localparam state_t S_LATCH = 3'd2;
   localparam state_t S_SUM   = 3'd3;
   localparam state_t S_READY = 3'd4;

   // Upper-case hex digit: 0-9 -> 30-39, A-F -> 41-46.
   function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
      logic [7:0] c;
      if (nib < 4'd10) begin
         c = 8'h30 + {4'h0, nib};
      end else begin
         c = 8'h37 + {4'h0, nib};
      end
      return c;
   endfunction

   // Header layout "J7W" + version + "J72" + gencode + "93".
   function automatic logic [7:0] header_byte(
      input logic [3:0] idx,
      input logic [7:0] version,
      input logic [7:0] gencode
   );
      logic [7:0] b;
      case (idx)
         4'd0, 4'd4: b = HDR_J;
         4'd1, 4'd5: b = HDR_7;
         4'd2:       b = HDR_W;
         4'd3:       b = version;
         4'd6:       b = HDR_2;
         4'd7:       b = gencode;
         4'd8:       b = HDR_9;
         4'd9:       b = HDR_3;
         default:    b = 8'hff;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/peridot_infoblock_bytemux.sv
// Combinational image byte lookup: address + latched UID + checksum -> image byte.
// Addresses past the checksum byte read as 8'hff.
module peridot_infoblock_bytemux
   import peridot_infoblock_pkg::*;
#(
   parameter int unsigned AW              = 5,
   parameter int unsigned UID_NIBBLES     = 16,
   parameter logic [7:0]  BOARD_VERSION   = 8'h03,
   parameter logic [7:0]  PERIDOT_GENCODE = 8'h4e,
   parameter bit          CHECKSUM_ENABLE = 1'b1
) (
   input  logic [AW-1:0] addr_i,
   input  logic [63:0]   uid_i,
   input  logic [7:0]    checksum_i,
   output logic [7:0]    byte_o
);

   logic [7:0]  uid_ascii [16];
   int unsigned addr_int;

   for (genvar gi = 0; gi < 16; gi++) begin : g_nib
      assign uid_ascii[gi] = hex2ascii(uid_i[4*gi +: 4]);
   end

   assign addr_int = 32'(addr_i);

   // The most significant UID nibble lands at the lowest UID address.
   always_comb begin
      byte_o = 8'hff;
      if (addr_int < HDR_LEN) begin
         byte_o = header_byte(addr_int[3:0], BOARD_VERSION, PERIDOT_GENCODE);
      end else if (addr_int < UID_BASE + UID_NIBBLES) begin
         byte_o = uid_ascii[4'(UID_NIBBLES - 1 - (addr_int - UID_BASE))];
      end else if (addr_int == UID_BASE + UID_NIBBLES) begin
         byte_o = CHECKSUM_ENABLE ? checksum_i : 8'hff;
      end
   end

endmodule

// File: rtl/peridot_board_infoblock.sv
// Board serial-ROM image generator: fetches the chip UID, sums the image into a
// checksum byte, then serves the image through a registered 1-cycle read port.
module peridot_board_infoblock
   import peridot_infoblock_pkg::*;
#(
   parameter logic [7:0]  PERIDOT_GENCODE = 8'h4e,
   parameter logic [7:0]  BOARD_VERSION   = 8'h03,
   parameter int unsigned UID_NIBBLES     = 16,
   parameter logic [63:0] UID_VALUE       = 64'hffff_ffff_ffff_ffff,
   parameter bit          UID_ENABLE      = 1'b1,
   parameter int unsigned UID_WAIT_CYCLES = 16,
   parameter int unsigned UID_TIMEOUT     = 255,
   parameter bit          CHECKSUM_ENABLE = 1'b1,
   parameter int unsigned ROM_DEPTH       = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         ready,
   output logic                         uid_req,
   input  logic                         uid_valid_in,
   input  logic [63:0]                  uid_data_in,
   output logic [63:0]                  uid,
   output logic                         uid_fault,
   input  logic                         rd_req,
   input  logic [$clog2(ROM_DEPTH)-1:0] rd_addr,
   output logic                         rd_ack,
   output logic [7:0]                   rd_data
);

   localparam int unsigned AW = $clog2(ROM_DEPTH);
   localparam logic [63:0] UID_MASK = (UID_NIBBLES >= 16) ? {64{1'b1}}
                                    : ((64'd1 << (4 * UID_NIBBLES)) - 64'd1);
   localparam logic [7:0]    WAIT_LAST = 8'(UID_WAIT_CYCLES - 1);
   localparam logic [15:0]   TMO_LAST  = 16'(UID_TIMEOUT - 1);
   localparam logic [AW-1:0] WALK_LAST = AW'(HDR_LEN + UID_NIBBLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    wait_q, wait_d;
   logic [15:0]   tmo_q, tmo_d;
   logic [AW-1:0] walk_q, walk_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    checksum_q, checksum_d;
   logic [63:0]   uid_q, uid_d;
   logic          fault_q, fault_d;
   logic          rd_ack_q;
   logic [7:0]    rd_data_q;
   logic [7:0]    walk_byte;
   logic [7:0]    rd_byte;

   // The walker never reaches the checksum address, so it sees a zero checksum.
   peridot_infoblock_bytemux #(
      .AW              (AW),
      .UID_NIBBLES     (UID_NIBBLES),
      .BOARD_VERSION   (BOARD_VERSION),
      .PERIDOT_GENCODE (PERIDOT_GENCODE),
      .CHECKSUM_ENABLE (CHECKSUM_ENABLE)
   ) u_walk_mux (
      .addr_i     (walk_q),
      .uid_i      (uid_q),
      .checksum_i (8'h00),
      .byte_o     (walk_byte)
   );

   peridot_infoblock_bytemux #(
      .AW              (AW),
      .UID_NIBBLES     (UID_NIBBLES),
      .BOARD_VERSION   (BOARD_VERSION),
      .PERIDOT_GENCODE (PERIDOT_GENCODE),
      .CHECKSUM_ENABLE (CHECKSUM_ENABLE)
   ) u_rd_mux (
      .addr_i     (rd_addr),
      .uid_i      (uid_q),
      .checksum_i (checksum_q),
      .byte_o     (rd_byte)
   );

   always_comb begin
      state_d    = state_q;
      wait_d     = wait_q;
      tmo_d      = tmo_q;
      walk_d     = walk_q;
      sum_d      = sum_q;
      checksum_d = checksum_q;
      uid_d      = uid_q;
      fault_d    = fault_q;
      case (state_q)
         S_WAIT: begin
            if (wait_q == WAIT_LAST) begin
               state_d = UID_ENABLE ? S_REQ : S_LATCH;
               tmo_d   = '0;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_REQ: begin
            // A valid on the final timeout cycle still wins over the fallback.
            if (uid_valid_in) begin
               uid_d   = uid_data_in & UID_MASK;
               fault_d = 1'b0;
               state_d = S_SUM;
            end else if (tmo_q == TMO_LAST) begin
               uid_d   = UID_VALUE & UID_MASK;
               fault_d = 1'b1;
               state_d = S_SUM;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         S_LATCH: begin
            uid_d   = UID_VALUE & UID_MASK;
            fault_d = 1'b0;
            state_d = S_SUM;
         end
         S_SUM: begin
            sum_d = sum_q + walk_byte;
            if (walk_q == WALK_LAST) begin
               checksum_d = 8'd0 - sum_d;
               state_d    = S_READY;
            end else begin
               walk_d = walk_q + 1'b1;
            end
         end
         S_READY: begin
            state_d = S_READY;
         end
         default: begin
            state_d = S_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_WAIT;
         wait_q     <= '0;
         tmo_q      <= '0;
         walk_q     <= '0;
         sum_q      <= '0;
         checksum_q <= '0;
         uid_q      <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_q     <= wait_d;
         tmo_q      <= tmo_d;
         walk_q     <= walk_d;
         sum_q      <= sum_d;
         checksum_q <= checksum_d;
         uid_q      <= uid_d;
         fault_q    <= fault_d;
      end
   end

   // Every request is acked; the data is 8'hff until the image is complete.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ack_q  <= 1'b0;
         rd_data_q <= 8'hff;
      end else begin
         rd_ack_q <= rd_req;
         if (rd_req) begin
            rd_data_q <= (state_q == S_READY) ? rd_byte : 8'hff;
         end
      end
   end

   assign ready     = (state_q == S_READY);
   assign uid_req   = (state_q == S_REQ);
   assign uid       = uid_q;
   assign uid_fault = fault_q;
   assign rd_ack    = rd_ack_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_peridot_board_infoblock.sv
// Scoreboard bench: two instances (16- and 8-nibble UID) driven with random reads and
// UID handshake timings, checked against an image model built from the layout rules.
module tb_peridot_board_infoblock;

   localparam int W     = 16;
   localparam int T     = 255;
   localparam int NEVER = 100000;

   typedef struct {
      int         addr;
      logic [7:0] e0;
      logic [7:0] e1;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic [4:0]  rd_addr;
   logic        ready [2];
   logic        uid_req [2];
   logic        uid_valid_in [2];
   logic        uid_fault [2];
   logic        rd_ack [2];
   logic [63:0] uid_data_in [2];
   logic [63:0] uid [2];
   logic [7:0]  rd_data [2];

   int          nib [2] = '{16, 8};
   int          valid_at [2];
   logic [63:0] src_uid [2];
   logic [7:0]  hdr [10] = '{8'h4a, 8'h37, 8'h57, 8'h03, 8'h4a, 8'h37, 8'h32, 8'h4e, 8'h39, 8'h33};
   string       hexdig = "0123456789ABCDEF";
   rd_exp_t     sb [$];
   int          cnt = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   always #5 clk = ~clk;

   peridot_board_infoblock dut0 (
      .clk(clk), .reset(reset), .ready(ready[0]), .uid_req(uid_req[0]),
      .uid_valid_in(uid_valid_in[0]), .uid_data_in(uid_data_in[0]), .uid(uid[0]),
      .uid_fault(uid_fault[0]), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack[0]), .rd_data(rd_data[0])
   );

   peridot_board_infoblock #(.UID_NIBBLES(8)) dut1 (
      .clk(clk), .reset(reset), .ready(ready[1]), .uid_req(uid_req[1]),
      .uid_valid_in(uid_valid_in[1]), .uid_data_in(uid_data_in[1]), .uid(uid[1]),
      .uid_fault(uid_fault[1]), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_ack(rd_ack[1]), .rd_data(rd_data[1])
   );

   // Cycle index since the last sampled reset (0 = first cycle after that edge).
   always @(posedge clk) begin
      if (reset) cnt <= 0;
      else       cnt <= cnt + 1;
   end

   // ---------------- reference model ----------------
   function automatic bit timed_out(input int d);
      return valid_at[d] > W + T - 1;
   endfunction

   function automatic int latch_cyc(input int d);
      return timed_out(d) ? (W + T - 1) : valid_at[d];
   endfunction

   function automatic int ready_at(input int d);
      return latch_cyc(d) + 11 + nib[d];
   endfunction

   function automatic logic [63:0] exp_uid(input int d);
      logic [63:0] u;
      u = timed_out(d) ? 64'hffff_ffff_ffff_ffff : src_uid[d];
      if (nib[d] < 16) u = u & ((64'd1 << (4 * nib[d])) - 64'd1);
      return u;
   endfunction

   function automatic logic [7:0] body_byte(input int d, input int a);
      logic [63:0] u;
      int          k;
      if (a < 10) return hdr[a];
      u = exp_uid(d) >> (4 * (nib[d] - 1 - (a - 10)));
      k = int'(u[3:0]);
      return 8'(hexdig[k]);
   endfunction

   function automatic logic [7:0] img_byte(input int d, input int a);
      int s;
      s = 0;
      if (a < 10 + nib[d]) return body_byte(d, a);
      if (a == 10 + nib[d]) begin
         for (int k = 0; k < 10 + nib[d]; k++) s += int'(body_byte(d, k));
         return 8'((256 - (s % 256)) % 256);
      end
      return 8'hff;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, d, cnt, act, exp);
      end
   endtask

   initial begin
      rd_exp_t e;
      wait (mon_en);
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) begin
            chk("ready", d, 64'(ready[d]), 64'(cnt >= ready_at(d)));
            chk("uid_req", d, 64'(uid_req[d]), 64'(cnt >= W && cnt <= latch_cyc(d)));
            chk("uid_fault", d, 64'(uid_fault[d]), 64'(cnt > latch_cyc(d) && timed_out(d)));
            chk("uid", d, uid[d], (cnt > latch_cyc(d)) ? exp_uid(d) : 64'd0);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rd_ack", 0, 64'(rd_ack[0]), 64'd1);
            chk("rd_ack", 1, 64'(rd_ack[1]), 64'd1);
            chk("rd_data", 0, 64'(rd_data[0]), 64'(e.e0));
            chk("rd_data", 1, 64'(rd_data[1]), 64'(e.e1));
            $display("rd addr=%0d dut0=%02h (exp %02h) dut1=%02h (exp %02h)",
                     e.addr, rd_data[0], e.e0, rd_data[1], e.e1);
         end else begin
            chk("rd_ack_idle", 0, 64'(rd_ack[0]), 64'd0);
            chk("rd_ack_idle", 1, 64'(rd_ack[1]), 64'd0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit rst, input bit do_rd, input int addr);
      rd_exp_t e;
      @(negedge clk);
      reset = rst;
      for (int d = 0; d < 2; d++) begin
         uid_valid_in[d] = (cnt == valid_at[d]);
         uid_data_in[d]  = uid_valid_in[d] ? src_uid[d] : {$urandom, $urandom};
      end
      rd_req  = do_rd;
      rd_addr = 5'(addr);
      if (do_rd && !rst) begin
         e.addr = addr;
         e.e0   = (cnt >= ready_at(0)) ? img_byte(0, addr) : 8'hff;
         e.e1   = (cnt >= ready_at(1)) ? img_byte(1, addr) : 8'hff;
         sb.push_back(e);
      end
   endtask

   task automatic rand_cycles(input int n);
      int a;
      for (int i = 0; i < n; i++) begin
         a = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 7 : 0)
                                         : int'($urandom_range(0, 31));
         step(1'b0, 1'($urandom_range(0, 1)), a);
      end
   endtask

   task automatic sweep();
      for (int a = 0; a < 32; a++) step(1'b0, 1'b1, a);
      step(1'b0, 1'b0, 0);
   endtask

   task automatic start(input int va0, input int va1, input logic [63:0] u0, input logic [63:0] u1);
      step(1'b1, 1'b0, 0);
      valid_at[0] = va0;
      valid_at[1] = va1;
      src_uid[0]  = u0;
      src_uid[1]  = u1;
      step(1'b1, 1'($urandom_range(0, 1)), 3);
      chk("rst_rd_data", 0, 64'(rd_data[0]), 64'hff);
      chk("rst_rd_data", 1, 64'(rd_data[1]), 64'hff);
   endtask

   initial begin
      int va;
      reset   = 1'b1;
      rd_req  = 1'b0;
      rd_addr = '0;
      for (int d = 0; d < 2; d++) begin
         uid_valid_in[d] = 1'b0;
         uid_data_in[d]  = '0;
         valid_at[d]     = NEVER;
         src_uid[d]      = '0;
      end
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
      mon_en = 1'b1;

      // Source UID 5 cycles into the request; the 8-nibble part gets junk above bit 31.
      start(W + 5, W + 5, 64'h0123_4567_89AB_CDEF, 64'h1234_5678_DEAD_BEEF);
      rand_cycles(60);
      sweep();

      // Reset in the middle of the checksum walk with a read pending, then a full rerun.
      start(W + 5, W + 5, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_DEAD_BEEF);
      rand_cycles(W + 5 + 8);
      step(1'b1, 1'b1, 7);
      rand_cycles(60);
      sweep();

      // No valid at all: timeout fallback.
      start(NEVER, NEVER, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_DEAD_BEEF);
      rand_cycles(320);
      sweep();

      // Valid lands on the final timeout cycle.
      start(W + T - 1, W + T - 1, {$urandom, $urandom}, {$urandom, $urandom});
      rand_cycles(320);
      sweep();

      // Random handshake timings, including valid arriving only after the timeout.
      for (int it = 0; it < 3; it++) begin
         va = ($urandom_range(0, 3) == 0) ? (W + T + int'($urandom_range(20, 40)))
                                          : (W + int'($urandom_range(0, T - 1)));
         start(va, W + int'($urandom_range(0, T - 1)), {$urandom, $urandom}, {$urandom, $urandom});
         rand_cycles(340);
         sweep();
      end

      step(1'b0, 1'b0, 0);
      chk("sb_drained", 0, 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
